led_display_scheduler: RTL
==========================

// Module: led_display_scheduler
// PURPOSE
//   Owns the 8-LED bar and shares it between two users: a ping-pong "chaser" idle pattern and
//   note indications from the tone-organ keyboard/player path. A valid/ready note request
//   preempts the chaser for HOLD_TICKS display ticks, then the chaser resumes at its saved
//   position. An internal prescaler generates the display tick.
// PARAMETERS
//   TICK_DIV    12_500_000  clk cycles per display tick; must be >= 2
//   HOLD_TICKS  4           ticks a note stays displayed; must be >= 1 (elaboration error otherwise)
// PORTS
//   clk          in   1  system clock
//   rst          in   1  synchronous, active-high reset
//   pause        in   1  1 = freeze the tick prescaler; the handshake keeps working
//   note_valid   in   1  note request valid
//   note_code    in   3  LED index 0..7 to light for the note
//   note_ready   out  1  1 = request can be accepted this cycle
//   showing      out  1  1 = a note is currently displayed (state SHOW)
//   led          out  8  LED bar drive, bit0 = rightmost
// BEHAVIOUR
//   Reset: led=8'h01, chase dir=left, state=CHASE, tick_cnt=0, hold_cnt=0, note_ready=1, showing=0.
//   Tick: tick_cnt counts 0..TICK_DIV-1 and wraps to 0; tick=1 for one cycle when tick_cnt==TICK_DIV-1.
//     pause=1 holds tick_cnt and forces tick=0.
//   Transfer: happens when note_valid && note_ready at a clk edge. note_ready=1 in CHASE and SHOW, 0 in RESUME.
//   FSM states: CHASE, SHOW, RESUME.
//   CHASE:
//     On tick, direction left: if led[7], then led<=led>>1 and dir<=right; else led<=led<<1.
//     Direction right is the mirror case, using led[0].
//     Sequence: 01,02,..,80,40,..,01,02,..; period 14 ticks.
//     On transfer: save {led,dir}, led<=1<<note_code, hold_cnt<=HOLD_TICKS, go to SHOW.
//     Transfer on the same cycle as a tick: the transfer wins, the chaser does not step,
//     and the saved value is the pre-tick led.
//   SHOW:
//     On tick, hold_cnt decrements. A tick with hold_cnt==1 moves to RESUME.
//     Transfer in SHOW (retrigger): led<=1<<note_code, hold_cnt<=HOLD_TICKS; the saved chase
//     position is left unchanged. A retrigger coinciding with the final tick: the retrigger wins
//     and the block stays in SHOW.
//   RESUME: one cycle; led<=saved led, dir<=saved dir, then go to CHASE. No tick-driven step in this cycle.
//   Timing: showing and led are registered, so both change one cycle after the transfer edge.
//     note_ready is decoded from state.
//   Widths: tick_cnt is $clog2(TICK_DIV) bits; hold_cnt is $clog2(HOLD_TICKS+1) bits. No overflow is possible.
//   Invariant: led is one-hot in all states without the optional feature.
//   rst asserted in any state, including mid-SHOW: all registers take their reset values at the
//     next edge and the saved position is discarded.
// CONFIGURATION
//   LED_SCHED_BLINK_EN defined: in SHOW, led toggles between 1<<note_code and 8'h00 on every tick.
//     Each accept or retrigger starts lit. hold_cnt counting is unchanged.
//   Not defined: the note LED is steady for the whole of SHOW.
// STRUCTURE
//   Package led_pkg holds: the state enum (CHASE, SHOW, RESUME), the LED_RESET=8'h01 constant,
//     and the dir encoding (DIR_LEFT=1'b1, DIR_RIGHT=1'b0).
//   Sub-module led_tick_gen (params TICK_DIV; ports clk, rst, pause -> tick) holds the prescaler.
//   The FSM, chaser and save registers stay in this module.
// TESTING (TICK_DIV=4, HOLD_TICKS=3)
//   1. Release rst, no notes -> led=01; 02 after 4 cycles; 80 after 28; 40 after 32; note_ready=1 throughout.
//   2. Wait until led=04 (dir left), pulse note_code=5 -> next cycle led=20 and showing=1.
//      After 3 ticks, RESUME with note_ready=0 for 1 cycle, then led=04.
//      The next tick gives led=08.
//   3. Send note 2; after 1 tick send note 7 -> led=80 and hold restarts.
//      Return happens 3 ticks after the second accept, to the position saved at the first accept.
//   4. Assert note_valid on the same cycle as a tick with led=10 -> led=1<<code.
//      After the hold, led returns to 10, not 20.
//   5. Hold pause=1 for 20 cycles in CHASE and in SHOW -> led is unchanged and the hold does not expire.
//      A note is still accepted while paused.
//   6. Assert rst for 1 cycle mid-SHOW -> led=01, showing=0, note_ready=1; chase restarts from 01 going left.
//      With LED_SCHED_BLINK_EN, also check led=20,00,20 on successive ticks in SHOW.

Source files
------------

// File: rtl/led_display_scheduler_pkg.sv
// Shared types and constants for the LED display scheduler.
package led_pkg;

  localparam int unsigned LED_W  = 8;
  localparam int unsigned NOTE_W = 3;

  localparam logic [LED_W-1:0] LED_RESET = 8'h01;
  localparam logic             DIR_LEFT  = 1'b1;
  localparam logic             DIR_RIGHT = 1'b0;

  typedef enum logic [1:0] {
    CHASE  = 2'd0,
    SHOW   = 2'd1,
    RESUME = 2'd2
  } state_e;

  // Chaser position that is parked while a note is displayed
  typedef struct packed {
    logic [LED_W-1:0] led;
    logic             dir;
  } chase_pos_t;

  function automatic logic [LED_W-1:0] note_onehot(input logic [NOTE_W-1:0] code);
    return LED_W'(1) << code;
  endfunction

endpackage

// File: rtl/led_display_scheduler_if.sv
// Note request valid/ready channel into the LED display scheduler.
interface led_display_scheduler_if;
  import led_pkg::*;

  logic              note_valid;
  logic [NOTE_W-1:0] note_code;
  logic              note_ready;

  modport master (output note_valid, output note_code, input note_ready);
  modport slave  (input note_valid, input note_code, output note_ready);

endinterface

// File: rtl/led_display_scheduler_tick_gen.sv
// Display tick prescaler: one-cycle tick every TICK_DIV unpaused cycles.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pause,
  output logic tick
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("led_tick_gen: TICK_DIV must be >= 2");
  end

  logic [TICK_W-1:0] tick_cnt_q;
  logic [TICK_W-1:0] tick_cnt_d;

  assign tick = !pause && (tick_cnt_q == TICK_LAST);

  // Next count: hold while paused, wrap at the last value
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!pause) begin
      if (tick_cnt_q == TICK_LAST) tick_cnt_d = '0;
      else                         tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/led_display_scheduler.sv
// LED bar owner: ping-pong chaser, preempted by note requests for HOLD_TICKS ticks.
// Optional build macro LED_SCHED_BLINK_EN: note LED blinks on every tick while shown.
module led_display_scheduler
  import led_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pause,
  led_display_scheduler_if.slave  note,
  output logic                    showing,
  output logic [LED_W-1:0]        led
);

  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("led_display_scheduler: HOLD_TICKS must be >= 1");
  end

  logic tick;
  logic xfer;

  state_e            state_q,   state_d;
  logic [LED_W-1:0]  led_q,     led_d;
  logic              dir_q,     dir_d;
  chase_pos_t        saved_q,   saved_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;
  logic              showing_q, showing_d;
`ifdef LED_SCHED_BLINK_EN
  logic [LED_W-1:0]  note_led_q, note_led_d;
`endif

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .pause (pause),
    .tick  (tick)
  );

  assign note.note_ready = (state_q != RESUME);
  assign xfer            = note.note_valid && note.note_ready;
  assign led             = led_q;
  assign showing         = showing_q;

  // Next-state, chaser stepping, note capture and restore
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    dir_d   = dir_q;
    saved_d = saved_q;
    hold_d  = hold_q;
`ifdef LED_SCHED_BLINK_EN
    note_led_d = note_led_q;
`endif
    unique case (state_q)
      CHASE: begin
        if (xfer) begin
          saved_d = '{led: led_q, dir: dir_q};
          led_d   = note_onehot(note.note_code);
          hold_d  = HOLD_LOAD;
          state_d = SHOW;
`ifdef LED_SCHED_BLINK_EN
          note_led_d = note_onehot(note.note_code);
`endif
        end else if (tick) begin
          if (dir_q == DIR_LEFT) begin
            if (led_q[LED_W-1]) begin
              led_d = led_q >> 1;
              dir_d = DIR_RIGHT;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_d = led_q << 1;
              dir_d = DIR_LEFT;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
      end
      SHOW: begin
        if (xfer) begin
          led_d  = note_onehot(note.note_code);
          hold_d = HOLD_LOAD;
`ifdef LED_SCHED_BLINK_EN
          note_led_d = note_onehot(note.note_code);
`endif
        end else if (tick) begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q == HOLD_W'(1)) state_d = RESUME;
`ifdef LED_SCHED_BLINK_EN
          led_d = (led_q == '0) ? note_led_q : '0;
`endif
        end
      end
      RESUME: begin
        led_d   = saved_q.led;
        dir_d   = saved_q.dir;
        state_d = CHASE;
      end
      default: state_d = CHASE;
    endcase
    showing_d = (state_d == SHOW);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CHASE;
      led_q      <= LED_RESET;
      dir_q      <= DIR_LEFT;
      saved_q    <= '{led: LED_RESET, dir: DIR_LEFT};
      hold_q     <= '0;
      showing_q  <= 1'b0;
`ifdef LED_SCHED_BLINK_EN
      note_led_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      led_q      <= led_d;
      dir_q      <= dir_d;
      saved_q    <= saved_d;
      hold_q     <= hold_d;
      showing_q  <= showing_d;
`ifdef LED_SCHED_BLINK_EN
      note_led_q <= note_led_d;
`endif
    end
  end

endmodule
